// File: rtl/bgr_startup_ctrl_if.sv
// Control/status bundle between the bandgap start-up sequencer and its
// neighbours. The master is the power manager / analog side, and the slave is
// the sequencer.
interface bgr_startup_ctrl_if;
  logic       enable;
  logic       vbg_ok;
  logic       porst;
  logic       bgr_ready;
  logic       bgr_fail;
  logic [2:0] retry_cnt;
  logic [2:0] state;

  modport master (
    output enable,
    output vbg_ok,
    input  porst,
    input  bgr_ready,
    input  bgr_fail,
    input  retry_cnt,
    input  state
  );

  modport slave (
    input  enable,
    input  vbg_ok,
    output porst,
    output bgr_ready,
    output bgr_fail,
    output retry_cnt,
    output state
  );
endinterface

// File: rtl/bgr_startup_ctrl.sv
// Bandgap start-up sequencer.
//
// The sequencer kicks the bgr_top current mirror through porst, waits for the
// reference to settle, and then qualifies it against the synchronized
// comparator flag. It retries the kick a bounded number of times before it
// reports ready or fail.
//
// Optional build macro: BGR_STARTUP_MONITOR_EN. When it is defined, the
// sequencer watches for vbg_ok dropouts in RUN and re-kicks the reference.
module bgr_startup_ctrl #(
  parameter int unsigned PORST_CYCLES  = 16,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned DROP_CYCLES   = 8,
  parameter int unsigned CNT_W         = 16
) (
  input logic               clk,
  input logic               rst_n,
  bgr_startup_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StKick   = 3'd1,
    StSettle = 3'd2,
    StRun    = 3'd3,
    StFail   = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] PorstLast  = CNT_W'(PORST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
  localparam logic [2:0]       MaxRetry   = 3'(MAX_RETRIES);
`ifdef BGR_STARTUP_MONITOR_EN
  localparam logic [CNT_W-1:0] DropLast   = CNT_W'(DROP_CYCLES - 1);
`endif

  // Reject parameter sets that would make the counters compare against
  // unreachable values.
  if (PORST_CYCLES < 1) begin : g_bad_porst
    $error("PORST_CYCLES must be >= 1");
  end
  if (SETTLE_CYCLES < 2) begin : g_bad_settle
    $error("SETTLE_CYCLES must be >= 2");
  end
  if (MAX_RETRIES > 7) begin : g_bad_retries
    $error("MAX_RETRIES must be in 0..7");
  end
  if (DROP_CYCLES < 1) begin : g_bad_drop
    $error("DROP_CYCLES must be >= 1");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       retry_q, retry_d;
  logic [1:0]       sync_q;
  logic             ok_s;

  assign ok_s = sync_q[1];

  // Register the state, the counters and the two-flop vbg_ok synchronizer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      retry_q <= '0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      sync_q  <= {sync_q[0], bus.vbg_ok};
    end
  end

  // Compute the next state. A low enable overrides every other transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    if (!bus.enable) begin
      state_d = StIdle;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StKick;
          cnt_d   = '0;
          retry_d = '0;
        end
        StKick: begin
          if (cnt_q == PorstLast) begin
            state_d = StSettle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StSettle: begin
          if (cnt_q == SettleLast) begin
            cnt_d = '0;
            if (ok_s) begin
              state_d = StRun;
            end else if (retry_q < MaxRetry) begin
              retry_d = retry_q + 3'd1;
              state_d = StKick;
            end else begin
              state_d = StFail;
            end
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StRun: begin
`ifdef BGR_STARTUP_MONITOR_EN
          // In RUN, cnt counts consecutive low ok_s cycles.
          if (ok_s) begin
            cnt_d = '0;
          end else if (cnt_q == DropLast) begin
            cnt_d = '0;
            if (retry_q < MaxRetry) begin
              retry_d = retry_q + 3'd1;
              state_d = StKick;
            end else begin
              state_d = StFail;
            end
          end else begin
            cnt_d = cnt_q + CntOne;
          end
`else
          cnt_d = '0;
`endif
        end
        StFail: begin
          cnt_d = '0;
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
          retry_d = '0;
        end
      endcase
    end
  end

  // Decode the outputs from the registered state only.
  assign bus.porst     = (state_q == StKick);
  assign bus.bgr_ready = (state_q == StRun);
  assign bus.bgr_fail  = (state_q == StFail);
  assign bus.retry_cnt = retry_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_bgr_startup_ctrl.sv
// Directed bench for bgr_startup_ctrl with default parameters.
module tb_bgr_startup_ctrl;
  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   miscmp_cnt;
  int   cyc;
  int   pulses;

  bgr_startup_ctrl_if bus ();

  bgr_startup_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  // Advance n clocks and settle 1 ns past the last edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [2:0] st, input logic p,
                            input logic rdy, input logic fl, input logic [2:0] rc);
    check({tag, ".state"}, 32'(bus.state), 32'(st));
    check({tag, ".porst"}, 32'(bus.porst), 32'(p));
    check({tag, ".ready"}, 32'(bus.bgr_ready), 32'(rdy));
    check({tag, ".fail"}, 32'(bus.bgr_fail), 32'(fl));
    check({tag, ".retry"}, 32'(bus.retry_cnt), 32'(rc));
  endtask

  // Run from an enable rise until ready or fail. Count the cycles and the porst
  // pulses, and check the width of every pulse.
  task automatic bringup(input string tag, input int limit, output int cycles,
                         output int npulse);
    logic prev;
    int   width;
    prev   = bus.porst;
    width  = 0;
    cycles = 0;
    npulse = 0;
    while (!(bus.bgr_ready || bus.bgr_fail) && cycles < limit) begin
      step(1);
      cycles++;
      if (cycles == 1) check({tag, ".first_state"}, 32'(bus.state), 32'd1);
      if (bus.porst) begin
        if (!prev) npulse++;
        width++;
      end else if (prev) begin
        check({tag, ".porst_width"}, 32'(width), 32'd16);
        width = 0;
      end
      prev = bus.porst;
    end
    if (cycles >= limit) check({tag, ".timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    vec_cnt    = 0;
    miscmp_cnt = 0;
    rst_n      = 1'b0;
    bus.enable = 1'b0;
    bus.vbg_ok = 1'b1;
    step(3);
    check_outs("reset", 3'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    rst_n = 1'b1;
    step(2);
    check_outs("idle", 3'd0, 1'b0, 1'b0, 1'b0, 3'd0);

    // Good reference on the first try.
    bus.enable = 1'b1;
    bringup("t1", 3000, cyc, pulses);
    check("t1.cycles", 32'(cyc), 32'd1041);
    check("t1.pulses", 32'(pulses), 32'd1);
    check_outs("t1.run", 3'd3, 1'b0, 1'b1, 1'b0, 3'd0);

    // Low glitches on vbg_ok while in RUN.
`ifdef BGR_STARTUP_MONITOR_EN
    bus.vbg_ok = 1'b0;
    step(7);
    bus.vbg_ok = 1'b1;
    step(12);
    check_outs("glitch7", 3'd3, 1'b0, 1'b1, 1'b0, 3'd0);
    bus.vbg_ok = 1'b0;
    step(8);
    bus.vbg_ok = 1'b1;
    step(1);
    check("drop8.still_ready", 32'(bus.bgr_ready), 32'd1);
    step(2);
    check_outs("drop8.rekick", 3'd1, 1'b1, 1'b0, 1'b0, 3'd1);
`else
    bus.vbg_ok = 1'b0;
    step(8);
    bus.vbg_ok = 1'b1;
    step(12);
    check_outs("drop8.nomon", 3'd3, 1'b0, 1'b1, 1'b0, 3'd0);
`endif

    // A single retry: vbg_ok is low through the first SETTLE.
    bus.enable = 1'b0;
    step(2);
    check_outs("t2.idle", 3'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    bus.vbg_ok = 1'b0;
    bus.enable = 1'b1;
    fork
      begin
        step(1100);
        bus.vbg_ok = 1'b1;
      end
      bringup("t2", 4000, cyc, pulses);
    join
    check("t2.cycles", 32'(cyc), 32'd2081);
    check("t2.pulses", 32'(pulses), 32'd2);
    check_outs("t2.run", 3'd3, 1'b0, 1'b1, 1'b0, 3'd1);

    // Retries run out and the sequencer lands in FAIL.
    bus.enable = 1'b0;
    step(2);
    bus.vbg_ok = 1'b0;
    bus.enable = 1'b1;
    bringup("t3", 6000, cyc, pulses);
    check("t3.cycles", 32'(cyc), 32'd4161);
    check("t3.pulses", 32'(pulses), 32'd4);
    check_outs("t3.fail", 3'd4, 1'b0, 1'b0, 1'b1, 3'd3);
    step(5);
    check_outs("t3.sticky", 3'd4, 1'b0, 1'b0, 1'b1, 3'd3);
    bus.enable = 1'b0;
    step(1);
    check_outs("t3.clear", 3'd0, 1'b0, 1'b0, 1'b0, 3'd0);

    // Abort in the 5th cycle of KICK, then restart.
    bus.vbg_ok = 1'b1;
    bus.enable = 1'b1;
    step(5);
    check_outs("t4.kick5", 3'd1, 1'b1, 1'b0, 1'b0, 3'd0);
    bus.enable = 1'b0;
    step(1);
    check_outs("t4.abort", 3'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    bus.enable = 1'b1;
    bringup("t4", 3000, cyc, pulses);
    check("t4.cycles", 32'(cyc), 32'd1041);
    check("t4.pulses", 32'(pulses), 32'd1);

    // Reset during SETTLE, then a full restart with enable held high.
    bus.enable = 1'b0;
    step(1);
    bus.enable = 1'b1;
    step(100);
    check("t5.settle", 32'(bus.state), 32'd2);
    rst_n = 1'b0;
    step(1);
    check_outs("t5.reset", 3'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    rst_n = 1'b1;
    bringup("t5", 3000, cyc, pulses);
    check("t5.cycles", 32'(cyc), 32'd1041);
    check("t5.pulses", 32'(pulses), 32'd1);
    check_outs("t5.run", 3'd3, 1'b0, 1'b1, 1'b0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end
endmodule
